// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_e;

    localparam int unsigned DefaultTimeout = 16;
    localparam logic [31:0] WordZero       = 32'h0000_0000;

    // Master request fields that share a width across all instances
    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic        cyc;
        logic        stb;
    } wb_req_t;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog: counts consecutive unterminated strobe cycles and flags
// expiry when the count reaches TIMEOUT-1.
module wb_arb_watchdog
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic stall,
    input  logic clear,
    output logic expire
);

    localparam logic [7:0] Limit = 8'(TIMEOUT - 1);

    logic [7:0] count_q;

    // Expiry depends only on the registered count, so it never loops back
    // through a slave whose ack is combinational on strobe.
    assign expire = (count_q == Limit);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= 8'd0;
        end else if (clear || expire) begin
            count_q <= 8'd0;
        end else if (stall) begin
            count_q <= count_q + 8'd1;
        end
    end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin Wishbone arbiter with cycle lock and stall watchdog,
// sharing one slave port between instruction fetch (m0) and load/store (m1).
module wb_arbiter_2m
    import wb_arb_pkg::*;
#(
    parameter int unsigned SEL_W   = 8,
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic [31:0]      m0_adr_i,
    input  logic [31:0]      m0_dat_i,
    output logic [31:0]      m0_dat_o,
    input  logic [SEL_W-1:0] m0_sel_i,
    input  logic             m0_we_i,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    output logic             m0_rty_o,

    input  logic [31:0]      m1_adr_i,
    input  logic [31:0]      m1_dat_i,
    output logic [31:0]      m1_dat_o,
    input  logic [SEL_W-1:0] m1_sel_i,
    input  logic             m1_we_i,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic             m1_rty_o,

    output logic [31:0]      s_adr_o,
    output logic [31:0]      s_dat_o,
    output logic [SEL_W-1:0] s_sel_o,
    output logic             s_we_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    input  logic [31:0]      s_dat_i,
    input  logic             s_ack_i,
    input  logic             s_err_i,
    input  logic             s_rty_i,

    output logic [1:0]       gnt_o
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;       // 0 = m0 served last, 1 = m1
    logic [1:0] gnt_q;

    wb_req_t          m0_req, m1_req, own_req;
    logic [SEL_W-1:0] own_sel;
    logic             own_is_m1;
    logic             owner_valid;
    logic             stb_raw;
    logic             term;
    logic             wd_stall, wd_clear, wd_expire;
    logic             inject_err;

    assign m0_req = '{adr: m0_adr_i, dat: m0_dat_i, we: m0_we_i, cyc: m0_cyc_i, stb: m0_stb_i};
    assign m1_req = '{adr: m1_adr_i, dat: m1_dat_i, we: m1_we_i, cyc: m1_cyc_i, stb: m1_stb_i};

    // NOTE: every always_comb output gets a default first so no path through
    // the case leaves a variable unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? ARB_OWN0 : ARB_OWN1;
                end else if (m0_cyc_i) begin
                    state_d = ARB_OWN0;
                end else if (m1_cyc_i) begin
                    state_d = ARB_OWN1;
                end
            end
            ARB_OWN0: begin
                if (!m0_cyc_i) begin
                    last_d  = 1'b0;
                    state_d = m1_cyc_i ? ARB_OWN1 : ARB_IDLE;
                end
            end
            ARB_OWN1: begin
                if (!m1_cyc_i) begin
                    last_d  = 1'b1;
                    state_d = m0_cyc_i ? ARB_OWN0 : ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ARB_IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= {state_d == ARB_OWN1, state_d == ARB_OWN0};
        end
    end

    assign gnt_o = gnt_q;

    // The owner's signals reach the slave only while it still holds cyc,
    // which makes the handoff cycle show slave cyc low.
    assign own_is_m1   = (state_q == ARB_OWN1);
    assign own_req     = own_is_m1 ? m1_req : m0_req;
    assign own_sel     = own_is_m1 ? m1_sel_i : m0_sel_i;
    assign owner_valid = ((state_q == ARB_OWN0) && m0_cyc_i) ||
                         ((state_q == ARB_OWN1) && m1_cyc_i);
    assign stb_raw     = owner_valid && own_req.stb;
    assign term        = s_ack_i || s_err_i || s_rty_i;

    assign wd_stall   = stb_raw && !term;
    assign wd_clear   = !stb_raw || term || (state_d != state_q);
    // A real slave termination in the expiry cycle takes precedence.
    assign inject_err = wd_expire && stb_raw && !term;

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .stall  (wd_stall),
        .clear  (wd_clear),
        .expire (wd_expire)
    );

    always_comb begin
        s_adr_o  = WordZero;
        s_dat_o  = WordZero;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_dat_o = WordZero;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_rty_o = 1'b0;
        m1_dat_o = WordZero;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_rty_o = 1'b0;
        if (owner_valid) begin
            s_adr_o = own_req.adr;
            s_dat_o = own_req.dat;
            s_sel_o = own_sel;
            s_we_o  = own_req.we;
            s_cyc_o = 1'b1;
            s_stb_o = stb_raw && !wd_expire;
            if (own_is_m1) begin
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i || inject_err;
                m1_rty_o = s_rty_i;
            end else begin
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i || inject_err;
                m0_rty_o = s_rty_i;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m with a combinational-ack word memory slave.
module tb_wb_arbiter_2m;

    localparam int SelW = 4;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [31:0]     m0_adr_i, m0_dat_i, m0_dat_o;
    logic [SelW-1:0] m0_sel_i;
    logic            m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o, m0_rty_o;
    logic [31:0]     m1_adr_i, m1_dat_i, m1_dat_o;
    logic [SelW-1:0] m1_sel_i;
    logic            m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o, m1_rty_o;
    logic [31:0]     s_adr_o, s_dat_o, s_dat_i;
    logic [SelW-1:0] s_sel_o;
    logic            s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i, s_rty_i;
    logic [1:0]      gnt_o;

    int checks = 0;
    int errors = 0;

    wb_arbiter_2m #(.SEL_W(SelW), .TIMEOUT(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_sel_i(m0_sel_i),
        .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_sel_i(m1_sel_i),
        .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .gnt_o(gnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Word memory at 0x0000_0000-0x0000_0FFF; anything else is never acked
    logic [31:0] mem [0:1023];
    logic        slv_hit;

    assign slv_hit = s_cyc_o && s_stb_o && (s_adr_o[31:12] == 20'h0) && (s_adr_o[1:0] == 2'b00);
    assign s_ack_i = slv_hit;
    assign s_err_i = 1'b0;
    assign s_rty_i = 1'b0;
    assign s_dat_i = mem[s_adr_o[11:2]];

    always @(posedge clk_i) begin
        if (!rst_i) begin
            mem[10'h040] <= 32'hDEAD_BEEF;
            mem[10'h080] <= 32'hAABB_CCDD;
        end else if (slv_hit && s_we_o) begin
            for (int b = 0; b < 4; b++) begin
                if (s_sel_o[b]) mem[s_adr_o[11:2]][b*8 +: 8] <= s_dat_o[b*8 +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_all();
        m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_we_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_we_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    endtask

    task automatic m0_read(input logic [31:0] adr);
        m0_adr_i = adr; m0_we_i = 0; m0_sel_i = '1; m0_cyc_i = 1; m0_stb_i = 1;
    endtask

    task automatic m1_read(input logic [31:0] adr);
        m1_adr_i = adr; m1_we_i = 0; m1_sel_i = '1; m1_cyc_i = 1; m1_stb_i = 1;
    endtask

    function automatic logic [31:0] m1_resp();
        return {29'd0, m1_ack_o, m1_err_o, m1_rty_o};
    endfunction

    function automatic logic [31:0] m0_resp();
        return {29'd0, m0_ack_o, m0_err_o, m0_rty_o};
    endfunction

    initial begin
        #200000;
        $display("FAIL sim_timeout got=%0t exp=done", $time);
        $fatal(1, "time limit");
    end

    initial begin
        int first_err;
        logic [1:0] rr_exp [3];
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01;

        rst_i = 1'b0;
        idle_all();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_gnt", 32'(gnt_o), 32'h0);
        check("rst_s_cyc", {31'd0, s_cyc_o}, 32'h0);
        rst_i = 1'b1;

        // m0 alone reads 0x100
        step();
        m0_read(32'h100);
        @(negedge clk_i);
        check("t1_gnt_latency", 32'(gnt_o), 32'h0);
        step();
        @(negedge clk_i);
        check("t1_gnt", 32'(gnt_o), 32'h1);
        check("t1_m0_dat", m0_dat_o, 32'hDEAD_BEEF);
        check("t1_m0_resp", m0_resp(), 32'h4);
        check("t1_m1_dat", m1_dat_o, 32'h0);
        check("t1_m1_resp", m1_resp(), 32'h0);
        step();
        idle_all();
        @(negedge clk_i);
        check("t1_dead_gnt", 32'(gnt_o), 32'h1);
        check("t1_dead_s_cyc", {31'd0, s_cyc_o}, 32'h0);
        step();
        @(negedge clk_i);
        check("t1_idle_gnt", 32'(gnt_o), 32'h0);

        // Tie after reset: m0 first, handoff to m1 after one dead cycle
        rst_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        step();
        m0_read(32'h100);
        m1_read(32'h200);
        step();
        @(negedge clk_i);
        check("t2_tie_gnt", 32'(gnt_o), 32'h1);
        check("t2_m1_wait", m1_resp(), 32'h0);
        step();
        m0_cyc_i = 0; m0_stb_i = 0;
        @(negedge clk_i);
        check("t2_dead_gnt", 32'(gnt_o), 32'h1);
        step();
        @(negedge clk_i);
        check("t2_hand_gnt", 32'(gnt_o), 32'h2);
        check("t2_m1_dat", m1_dat_o, 32'hAABB_CCDD);
        step();
        idle_all();
        step();

        // Repeated ties alternate
        for (int r = 0; r < 3; r++) begin
            m0_read(32'h100);
            m1_read(32'h100);
            step();
            @(negedge clk_i);
            check($sformatf("t2_rr%0d_gnt", r), 32'(gnt_o), 32'(rr_exp[r]));
            step();
            idle_all();
            step();
        end

        // Lock: m0 holds cyc for 4 beats while m1 waits
        m0_read(32'h100);
        step();
        m1_read(32'h100);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk_i);
            check($sformatf("t3_beat%0d_gnt", b), 32'(gnt_o), 32'h1);
            check($sformatf("t3_beat%0d_m1", b), m1_resp(), 32'h0);
            step();
            if (b == 3) begin
                m0_cyc_i = 0; m0_stb_i = 0;
            end
        end
        @(negedge clk_i);
        check("t3_dead_m1", m1_resp(), 32'h0);
        step();
        @(negedge clk_i);
        check("t3_m1_gnt", 32'(gnt_o), 32'h2);
        check("t3_m1_ack", m1_resp(), 32'h4);
        step();
        idle_all();
        step();

        // Partial write by m1, read back by m0
        m1_adr_i = 32'h200; m1_dat_i = 32'h1122_3344; m1_sel_i = 4'h3;
        m1_we_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        step();
        @(negedge clk_i);
        check("t4_wr_ack", m1_resp(), 32'h4);
        step();
        idle_all();
        step();
        m0_read(32'h200);
        step();
        @(negedge clk_i);
        check("t4_rd_dat", m0_dat_o, 32'hAABB_3344);
        step();
        idle_all();
        step();

        // Watchdog on an address the slave never acks
        m1_read(32'h0010_0000);
        step();
        first_err = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (first_err >= 0 && k == first_err + 1) begin
                check("t5_err_single", {31'd0, m1_err_o}, 32'h0);
                break;
            end
            if (m1_err_o && first_err < 0) begin
                first_err = k;
                check("t5_stb_gated", {31'd0, s_stb_o}, 32'h0);
            end
            step();
        end
        check("t5_err_cycle", 32'(first_err), 32'd15);
        step();
        idle_all();
        step();
        step();

        // Reset mid-transfer in OWN1
        m1_read(32'h0010_0000);
        step();
        @(negedge clk_i);
        check("t6_pre_gnt", 32'(gnt_o), 32'h2);
        #2 rst_i = 1'b0;
        #1;
        check("t6_rst_gnt", 32'(gnt_o), 32'h0);
        check("t6_rst_s_cyc", {31'd0, s_cyc_o}, 32'h0);
        check("t6_rst_s_adr", s_adr_o, 32'h0);
        check("t6_rst_m1", m1_resp(), 32'h0);
        m0_read(32'h100);
        @(negedge clk_i);
        rst_i = 1'b1;
        step();
        @(negedge clk_i);
        check("t6_after_gnt", 32'(gnt_o), 32'h1);
        step();
        idle_all();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_2m.md
# wb_arbiter_2m

Two-master Wishbone arbiter placed in front of the single-ported memory controller. It lets the instruction-fetch master (m0) and the load/store master (m1) share one slave port. Arbitration is round-robin and locks for a whole `cyc` cycle. A per-transfer watchdog terminates a stalled access with an error. It sits between the nnARM core's two bus interfaces and the memory/peripheral slave.

## Interface
Parameters:
- `SEL_W`, 8: byte-select width, passed through unchanged to the slave.
- `TIMEOUT`, 16: number of stalled `stb` cycles before the watchdog error fires. Legal range is 2..255.

Ports (`mX_` means the same port exists as `m0_` and `m1_`):
- `clk_i`  in  1  single clock; all state updates on its rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `mX_adr_i`  in  32  master address.
- `mX_dat_i`  in  32  master write data.
- `mX_dat_o`  out  32  read data returned to the master.
- `mX_sel_i`  in  SEL_W  master byte selects.
- `mX_we_i`, `mX_cyc_i`, `mX_stb_i`  in  1  master cycle controls.
- `mX_ack_o`, `mX_err_o`, `mX_rty_o`  out  1  cycle terminations returned to the master.
- `s_adr_o`, `s_dat_o`, `s_sel_o`, `s_we_o`, `s_cyc_o`, `s_stb_o`  out  slave-side copies of the master signals, same widths as the master ports.
- `s_dat_i`  in  32  slave read data.
- `s_ack_i`, `s_err_i`, `s_rty_i`  in  1  slave terminations.
- `gnt_o`  out  2  one-hot grant; bit 0 = m0, bit 1 = m1; `2'b00` when idle.

## Operation
- FSM states: `IDLE`, `OWN0`, `OWN1`. State, grant and the last-served pointer `last` are registers.
- In `IDLE`:
  - Only m0 asserts `cyc`: go to `OWN0`.
  - Only m1 asserts `cyc`: go to `OWN1`.
  - Both assert `cyc`: grant the master that is not `last`.
  - Neither asserts `cyc`: stay in `IDLE`.
- In `OWNx`, while `mx_cyc_i` = 1:
  - The slave port carries master x's signals combinationally.
  - `s_ack_i`, `s_err_i`, `s_rty_i` and `s_dat_i` route to master x.
- When `mx_cyc_i` = 0 in `OWNx`:
  - `last` is set to x.
  - Next state is `OWNy` if the other master's `cyc` is high, otherwise `IDLE`.
- Non-granted master: `ack`/`err`/`rty` = 0 and `dat_o` = 0. Its `stb` is ignored and it simply waits.
- Slave outputs in `IDLE`: all 0.
- Watchdog:
  - An 8-bit counter increments in each `OWNx` cycle where `s_stb_o` = 1 and none of `ack`/`err`/`rty` is asserted.
  - The counter clears on any termination, on `stb` = 0, or on a grant change.
  - When the count equals `TIMEOUT`-1, `mx_err_o` = 1 and `s_stb_o` = 0 for that one cycle, then the counter clears.
- Simultaneous slave termination and watchdog expiry: the slave termination wins and no error is injected.
- Reset (`rst_i` low, any time, including mid-cycle):
  - State → `IDLE`, `last` → m1 so m0 wins the first tie, counter → 0.
  - Every output is 0 while `rst_i` is low.

## Timing
- Grant latency: 1 cycle. `cyc` sampled at edge N gives `gnt_o` and slave `cyc` during cycle N+1.
- Data path: zero-latency combinational in both directions while granted. With the combinational-ack memory slave, a single access completes in the first granted cycle.
- Handoff: 1 dead cycle. The cycle in which the owner drops `cyc` still shows its grant, with slave `cyc` low; the new owner appears the next cycle.
- Lock: the grant never changes while the owner's `cyc` is high, including across multiple `stb` beats.
- Watchdog fires exactly `TIMEOUT` cycles after `stb` first presents without a termination.

## Structure
- Package `wb_arb_pkg` holds:
  - state encoding constants `ARB_IDLE`, `ARB_OWN0`, `ARB_OWN1`;
  - the default `TIMEOUT`;
  - the `WordZero` constant.
- Sub-module `wb_arb_watchdog`: counter plus compare, with inputs `stall`, `clear` and output `expire`.
- Top level contains the FSM, the `last` register and the muxes.

## Test plan
- Reset release, m0 alone reads 0x100 (memory holds 0xDEADBEEF) → `gnt_o` = 01 one cycle after `cyc`; `m0_dat_o` = 0xDEADBEEF with `ack` in the same cycle; m1 outputs all 0.
- m0 and m1 raise `cyc` in the same cycle after reset → m0 granted first. When m0 drops `cyc`, one dead cycle, then `gnt_o` = 10. Repeat simultaneous requests → grant alternates 01, 10, 01.
- m0 holds `cyc` for 4 beats while m1 requests → `gnt_o` stays 01 for all 4 beats. m1 sees no `ack` until granted.
- m1 writes 0x11223344 with `sel` = 0x3 to 0x200, then m0 reads 0x200 → low half 0x3344 updated, upper bytes unchanged.
- Slave address 0x0010_0000, which the slave never acks → `m1_err_o` = 1 exactly 16 cycles after `stb`, single cycle, `s_stb_o` low in that cycle.
- Assert `rst_i` low mid-transfer in `OWN1` → `gnt_o` = 00 and all outputs 0 immediately. After release, a simultaneous request grants m0.
